// File: rtl/maze_nav_pkg.sv
// Shared types and helpers for the maze navigation controller: state codes,
// turn candidates and elaboration-time width helpers.
package maze_nav_pkg;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StForward    = 3'd1,
    StTurnLeft   = 3'd2,
    StTurnRight  = 3'd3,
    StTurnAround = 3'd4,
    StSettle     = 3'd5
  } nav_state_e;

  typedef enum logic [1:0] {
    CandStay   = 2'd0,
    CandLeft   = 2'd1,
    CandRight  = 2'd2,
    CandAround = 2'd3
  } nav_cand_e;

  localparam logic [2:0] StateCodeIdle    = 3'd0;
  localparam logic [2:0] StateCodeForward = 3'd1;
  localparam logic [2:0] StateCodeLeft    = 3'd2;
  localparam logic [2:0] StateCodeRight   = 3'd3;
  localparam logic [2:0] StateCodeAround  = 3'd4;
  localparam logic [2:0] StateCodeSettle  = 3'd5;

  function automatic int unsigned nav_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int unsigned nav_width(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  function automatic nav_state_e nav_cand_state(input nav_cand_e cand);
    nav_state_e st;
    case (cand)
      CandLeft:   st = StTurnLeft;
      CandRight:  st = StTurnRight;
      CandAround: st = StTurnAround;
      default:    st = StForward;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/nav_ir_qualifier.sv
// One IR channel's "open" flag. Define NAV_HYST_EN for set/clear hysteresis;
// otherwise the flag is a plain threshold compare on each valid sample.
module nav_ir_qualifier #(
  parameter int unsigned IR_W      = 16,
  parameter int unsigned THRESH_HI = 2000,
  parameter int unsigned THRESH_LO = 1800
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [IR_W-1:0] i_sample,
  output logic            o_open
);

  localparam logic [IR_W-1:0] ThreshHi = IR_W'(THRESH_HI);

  if (THRESH_LO > THRESH_HI) begin : g_bad_thresh
    $error("nav_ir_qualifier: THRESH_LO must not exceed THRESH_HI");
  end

  logic r_open;
  logic w_open_d;

`ifdef NAV_HYST_EN
  localparam logic [IR_W-1:0] ThreshLo = IR_W'(THRESH_LO);

  always_comb begin
    w_open_d = r_open;
    if (i_sample > ThreshHi) begin
      w_open_d = 1'b1;
    end else if (i_sample < ThreshLo) begin
      w_open_d = 1'b0;
    end
  end
`else
  always_comb begin
    w_open_d = (i_sample > ThreshHi);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_open <= 1'b0;
    end else if (i_valid) begin
      r_open <= w_open_d;
    end
  end

  assign o_open = r_open;

endmodule

// File: rtl/maze_nav_fsm.sv
// Wall-following maze navigator: qualifies IR samples, confirms a turn choice
// over several samples, then times turns and a settle period. See NAV_HYST_EN.
module maze_nav_fsm
  import maze_nav_pkg::*;
#(
  parameter int unsigned IR_W            = 16,
  parameter int unsigned RPM_W           = 26,
  parameter int unsigned FWD_RPM         = 100,
  parameter int unsigned TURN_FAST_RPM   = 100,
  parameter int unsigned TURN_SLOW_RPM   = 50,
  parameter int unsigned AROUND_RPM      = 100,
  parameter int unsigned THRESH_HI       = 2000,
  parameter int unsigned THRESH_LO       = 1800,
  parameter int unsigned CONFIRM_SAMPLES = 3,
  parameter int unsigned TURN_CYCLES     = 1000,
  parameter int unsigned AROUND_CYCLES   = 2000,
  parameter int unsigned SETTLE_CYCLES   = 500
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             enable_switch,
  input  logic             ir_valid,
  input  logic [IR_W-1:0]  right_ir,
  input  logic [IR_W-1:0]  left_ir,
  input  logic [IR_W-1:0]  forward_ir,
  output logic [RPM_W-1:0] rpm_left_setpoint,
  output logic [RPM_W-1:0] rpm_right_setpoint,
  output logic             left_motor_en,
  output logic             right_motor_en,
  output logic             left_motor_direction,
  output logic             right_motor_direction,
  output logic [2:0]       state_out,
  output logic             turn_done
);

  localparam int unsigned CntW   = nav_width(CONFIRM_SAMPLES + 1);
  localparam int unsigned TimerW =
      nav_width(nav_max(nav_max(TURN_CYCLES, AROUND_CYCLES), SETTLE_CYCLES));

  localparam logic [CntW-1:0]   CntTarget   = CntW'(CONFIRM_SAMPLES);
  localparam logic [TimerW-1:0] TurnLoad    = TimerW'(TURN_CYCLES - 1);
  localparam logic [TimerW-1:0] AroundLoad  = TimerW'(AROUND_CYCLES - 1);
  localparam logic [TimerW-1:0] SettleLoad  = TimerW'(SETTLE_CYCLES - 1);
  localparam logic [RPM_W-1:0]  RpmFwd      = RPM_W'(FWD_RPM);
  localparam logic [RPM_W-1:0]  RpmFast     = RPM_W'(TURN_FAST_RPM);
  localparam logic [RPM_W-1:0]  RpmSlow     = RPM_W'(TURN_SLOW_RPM);
  localparam logic [RPM_W-1:0]  RpmAround   = RPM_W'(AROUND_RPM);

  logic w_r_open, w_f_open, w_l_open;

  nav_ir_qualifier #(
    .IR_W      (IR_W),
    .THRESH_HI (THRESH_HI),
    .THRESH_LO (THRESH_LO)
  ) u_qual_right (
    .i_clk    (clk_in),
    .i_rst    (reset_in),
    .i_valid  (ir_valid),
    .i_sample (right_ir),
    .o_open   (w_r_open)
  );

  nav_ir_qualifier #(
    .IR_W      (IR_W),
    .THRESH_HI (THRESH_HI),
    .THRESH_LO (THRESH_LO)
  ) u_qual_forward (
    .i_clk    (clk_in),
    .i_rst    (reset_in),
    .i_valid  (ir_valid),
    .i_sample (forward_ir),
    .o_open   (w_f_open)
  );

  nav_ir_qualifier #(
    .IR_W      (IR_W),
    .THRESH_HI (THRESH_HI),
    .THRESH_LO (THRESH_LO)
  ) u_qual_left (
    .i_clk    (clk_in),
    .i_rst    (reset_in),
    .i_valid  (ir_valid),
    .i_sample (left_ir),
    .o_open   (w_l_open)
  );

  nav_state_e        r_state, w_state_d;
  nav_cand_e         r_prev_cand, w_prev_cand_d, w_cand;
  logic [CntW-1:0]   r_cnt, w_cnt_d, w_cnt_inc, w_cnt_new;
  logic [TimerW-1:0] r_timer, w_timer_d;
  logic              r_eval;
  logic              r_turn_done, w_turn_done_d;

  logic [RPM_W-1:0]  r_rpm_l, r_rpm_r, w_rpm_l_d, w_rpm_r_d;
  logic              r_en, r_dir_l, r_dir_r, w_en_d, w_dir_l_d, w_dir_r_d;

  // Right-hand wall follower priority.
  always_comb begin
    if (w_r_open) begin
      w_cand = CandRight;
    end else if (w_f_open) begin
      w_cand = CandStay;
    end else if (w_l_open) begin
      w_cand = CandLeft;
    end else begin
      w_cand = CandAround;
    end
  end

  always_comb begin
    w_cnt_inc = (r_cnt >= CntTarget) ? r_cnt : r_cnt + CntW'(1);
    w_cnt_new = (w_cand == r_prev_cand) ? w_cnt_inc : CntW'(1);
  end

  always_comb begin
    w_state_d     = r_state;
    w_prev_cand_d = r_prev_cand;
    w_cnt_d       = r_cnt;
    w_timer_d     = r_timer;
    w_turn_done_d = 1'b0;

    case (r_state)
      StIdle: begin
        w_cnt_d       = '0;
        w_prev_cand_d = CandStay;
        w_timer_d     = '0;
        if (enable_switch) begin
          w_state_d = StForward;
        end
      end
      StForward: begin
        if (r_eval) begin
          if (w_cand == CandStay) begin
            w_cnt_d       = '0;
            w_prev_cand_d = CandStay;
          end else if (w_cnt_new >= CntTarget) begin
            w_state_d     = nav_cand_state(w_cand);
            w_cnt_d       = '0;
            w_prev_cand_d = CandStay;
            w_timer_d     = (w_cand == CandAround) ? AroundLoad : TurnLoad;
          end else begin
            w_cnt_d       = w_cnt_new;
            w_prev_cand_d = w_cand;
          end
        end
      end
      StTurnLeft, StTurnRight, StTurnAround: begin
        if (r_timer == '0) begin
          w_state_d     = StSettle;
          w_timer_d     = SettleLoad;
          w_turn_done_d = 1'b1;
        end else begin
          w_timer_d = r_timer - TimerW'(1);
        end
      end
      StSettle: begin
        if (r_timer == '0) begin
          w_state_d     = StForward;
          w_cnt_d       = '0;
          w_prev_cand_d = CandStay;
        end else begin
          w_timer_d = r_timer - TimerW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (!enable_switch) begin
      w_state_d     = StIdle;
      w_cnt_d       = '0;
      w_prev_cand_d = CandStay;
      w_timer_d     = '0;
      w_turn_done_d = 1'b0;
    end
  end

  // Motor outputs are decoded from the next state so they update with it.
  always_comb begin
    w_en_d    = 1'b1;
    w_rpm_l_d = RpmFwd;
    w_rpm_r_d = RpmFwd;
    w_dir_l_d = 1'b1;
    w_dir_r_d = 1'b1;
    case (w_state_d)
      StIdle: begin
        w_en_d    = 1'b0;
        w_rpm_l_d = '0;
        w_rpm_r_d = '0;
      end
      StTurnLeft: begin
        w_rpm_l_d = RpmSlow;
        w_rpm_r_d = RpmFast;
      end
      StTurnRight: begin
        w_rpm_l_d = RpmFast;
        w_rpm_r_d = RpmSlow;
      end
      StTurnAround: begin
        w_rpm_l_d = RpmAround;
        w_rpm_r_d = RpmAround;
        w_dir_r_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state     <= StIdle;
      r_prev_cand <= CandStay;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_eval      <= 1'b0;
      r_turn_done <= 1'b0;
      r_en        <= 1'b0;
      r_rpm_l     <= '0;
      r_rpm_r     <= '0;
      r_dir_l     <= 1'b1;
      r_dir_r     <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_prev_cand <= w_prev_cand_d;
      r_cnt       <= w_cnt_d;
      r_timer     <= w_timer_d;
      r_eval      <= ir_valid;
      r_turn_done <= w_turn_done_d;
      r_en        <= w_en_d;
      r_rpm_l     <= w_rpm_l_d;
      r_rpm_r     <= w_rpm_r_d;
      r_dir_l     <= w_dir_l_d;
      r_dir_r     <= w_dir_r_d;
    end
  end

  assign rpm_left_setpoint     = r_rpm_l;
  assign rpm_right_setpoint    = r_rpm_r;
  assign left_motor_en         = r_en;
  assign right_motor_en        = r_en;
  assign left_motor_direction  = r_dir_l;
  assign right_motor_direction = r_dir_r;
  assign state_out             = r_state;
  assign turn_done             = r_turn_done;

endmodule

// File: tb/tb_maze_nav_fsm.sv
// Self-checking bench for maze_nav_fsm: directed scenarios plus randomized IR
// samples compared against a sample-level behavioural model.
module tb_maze_nav_fsm;

  localparam int IR_W    = 16;
  localparam int RPM_W   = 26;
  localparam int HI      = 2000;
  localparam int LO      = 1800;
  localparam int CONFIRM = 3;
  localparam int TURN    = 1000;
  localparam int AROUND  = 2000;
  localparam int SETTLE  = 500;
  localparam int FWD_R   = 100;
  localparam int FAST_R  = 100;
  localparam int SLOW_R  = 50;
  localparam int ARND_R  = 100;

  logic             clk_in = 1'b0;
  logic             reset_in = 1'b1;
  logic             enable_switch = 1'b0;
  logic             ir_valid = 1'b0;
  logic [IR_W-1:0]  right_ir = '0;
  logic [IR_W-1:0]  left_ir = '0;
  logic [IR_W-1:0]  forward_ir = '0;
  logic [RPM_W-1:0] rpm_left_setpoint;
  logic [RPM_W-1:0] rpm_right_setpoint;
  logic             left_motor_en;
  logic             right_motor_en;
  logic             left_motor_direction;
  logic             right_motor_direction;
  logic [2:0]       state_out;
  logic             turn_done;

  maze_nav_fsm dut (
    .clk_in                (clk_in),
    .reset_in              (reset_in),
    .enable_switch         (enable_switch),
    .ir_valid              (ir_valid),
    .right_ir              (right_ir),
    .left_ir               (left_ir),
    .forward_ir            (forward_ir),
    .rpm_left_setpoint     (rpm_left_setpoint),
    .rpm_right_setpoint    (rpm_right_setpoint),
    .left_motor_en         (left_motor_en),
    .right_motor_en        (right_motor_en),
    .left_motor_direction  (left_motor_direction),
    .right_motor_direction (right_motor_direction),
    .state_out             (state_out),
    .turn_done             (turn_done)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Model: open flags, expected state, streak of identical non-stay choices.
  bit       m_fr, m_ff, m_fl;
  logic [2:0] m_state;
  int       m_cnt;
  int       m_prev;  // 0 none/stay, 2 left, 3 right, 4 around (= turn state code)

  task automatic model_flag(inout bit f, input int s);
`ifdef NAV_HYST_EN
    if (s > HI) f = 1'b1;
    else if (s < LO) f = 1'b0;
`else
    f = (s > HI);
`endif
  endtask

  task automatic model_reset();
    m_fr = 0; m_ff = 0; m_fl = 0;
    m_state = 3'd0; m_cnt = 0; m_prev = 0;
  endtask

  // Drives one valid sample and one gap cycle, returning after the decision edge.
  task automatic send_sample(input int r, input int f, input int l);
    int choice;
    ir_valid = 1'b1;
    right_ir = IR_W'(r); forward_ir = IR_W'(f); left_ir = IR_W'(l);
    @(negedge clk_in);
    ir_valid = 1'b0;
    @(negedge clk_in);
    model_flag(m_fr, r);
    model_flag(m_ff, f);
    model_flag(m_fl, l);
    if (m_state == 3'd1) begin
      choice = m_fr ? 3 : m_ff ? 0 : m_fl ? 2 : 4;
      if (choice == 0) begin
        m_cnt = 0; m_prev = 0;
      end else begin
        m_cnt = (choice == m_prev) ? m_cnt + 1 : 1;
        m_prev = choice;
        if (m_cnt >= CONFIRM) begin
          m_state = 3'(choice); m_cnt = 0; m_prev = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset_in = 1'b1; enable_switch = 1'b0; ir_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    model_reset();
  endtask

  task automatic start_run();
    enable_switch = 1'b1;
    @(negedge clk_in);
    m_state = 3'd1; m_cnt = 0; m_prev = 0;
  endtask

  // Entered on the first cycle of a turn; follows it through settle to forward.
  task automatic run_turn(input logic [2:0] code);
    int n, pulses, len, el, er;
    logic edr;
    len = (code == 3'd4) ? AROUND : TURN;
    el = (code == 3'd2) ? SLOW_R : (code == 3'd3) ? FAST_R : ARND_R;
    er = (code == 3'd2) ? FAST_R : (code == 3'd3) ? SLOW_R : ARND_R;
    edr = (code == 3'd4) ? 1'b0 : 1'b1;
    total++;
    if ({left_motor_en, right_motor_en, left_motor_direction, right_motor_direction,
         rpm_left_setpoint, rpm_right_setpoint} !==
        {3'b111, edr, RPM_W'(el), RPM_W'(er)}) begin
      bad++;
      $display("FAIL turn_outputs st=%0d: got en=%b%b dir=%b%b L=%0d R=%0d want dir=1%b L=%0d R=%0d",
               code, left_motor_en, right_motor_en, left_motor_direction,
               right_motor_direction, rpm_left_setpoint, rpm_right_setpoint, edr, el, er);
    end
    n = 0; pulses = 0;
    while (state_out == code && n < len + 50) begin
      n++;
      if (turn_done) pulses++;
      @(negedge clk_in);
    end
    total++;
    if (n != len) begin
      bad++;
      $display("FAIL turn_len st=%0d: got %0d cycles want %0d", code, n, len);
    end
    total++;
    if (state_out !== 3'd5 || turn_done !== 1'b1) begin
      bad++;
      $display("FAIL settle_entry: got st=%0d done=%b want st=5 done=1", state_out, turn_done);
    end
    total++;
    if (rpm_left_setpoint !== RPM_W'(FWD_R) || rpm_right_setpoint !== RPM_W'(FWD_R) ||
        right_motor_direction !== 1'b1 || left_motor_en !== 1'b1) begin
      bad++;
      $display("FAIL settle_outputs: got L=%0d R=%0d dirR=%b en=%b want L=%0d R=%0d dirR=1 en=1",
               rpm_left_setpoint, rpm_right_setpoint, right_motor_direction, left_motor_en,
               FWD_R, FWD_R);
    end
    n = 0;
    while (state_out == 3'd5 && n < SETTLE + 50) begin
      n++;
      if (turn_done) pulses++;
      @(negedge clk_in);
    end
    total++;
    if (n != SETTLE || pulses != 1 || state_out !== 3'd1) begin
      bad++;
      $display("FAIL settle_len: got %0d cycles pulses=%0d st=%0d want %0d pulses=1 st=1",
               n, pulses, state_out, SETTLE);
    end
    m_state = 3'd1; m_cnt = 0; m_prev = 0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1; enable_switch = 1'b1;
    repeat (2) @(negedge clk_in);
    total++;
    if ({state_out, left_motor_en, right_motor_en, left_motor_direction,
         right_motor_direction, turn_done} !== {3'd0, 4'b0011, 1'b0} ||
        rpm_left_setpoint !== '0 || rpm_right_setpoint !== '0) begin
      bad++;
      $display("FAIL reset_state: got st=%0d en=%b%b dir=%b%b done=%b L=%0d R=%0d want idle",
               state_out, left_motor_en, right_motor_en, left_motor_direction,
               right_motor_direction, turn_done, rpm_left_setpoint, rpm_right_setpoint);
    end
    do_reset();
    @(negedge clk_in);
    total++;
    if (state_out !== 3'd0) begin
      bad++;
      $display("FAIL idle_hold: got st=%0d want 0", state_out);
    end
  endtask

  task automatic test_right_turn();
    start_run();
    total++;
    if (state_out !== 3'd1 || rpm_left_setpoint !== RPM_W'(FWD_R) || left_motor_en !== 1'b1) begin
      bad++;
      $display("FAIL enter_forward: got st=%0d L=%0d en=%b want st=1 L=%0d en=1",
               state_out, rpm_left_setpoint, left_motor_en, FWD_R);
    end
    for (int i = 0; i < 3; i++) begin
      send_sample(2500, 2500, 0);
      total++;
      if (state_out !== m_state) begin
        bad++;
        $display("FAIL right_confirm[%0d]: got st=%0d want %0d", i, state_out, m_state);
      end
    end
    if (state_out == 3'd3) run_turn(3'd3);
  endtask

  task automatic test_no_turn();
    int rs[8] = '{0, 0, 0, 2500, 2500, 0, 2500, 2500};
    for (int i = 0; i < 8; i++) begin
      send_sample(rs[i], 2500, 0);
      total++;
      if (state_out !== 3'd1 || state_out !== m_state) begin
        bad++;
        $display("FAIL no_turn[%0d]: got st=%0d want 1 (model %0d)", i, state_out, m_state);
      end
    end
    send_sample(2500, 2500, 0);
    total++;
    if (state_out !== 3'd3 || m_state !== 3'd3) begin
      bad++;
      $display("FAIL third_right: got st=%0d want 3 (model %0d)", state_out, m_state);
    end
    if (state_out == 3'd3) run_turn(3'd3);
  endtask

  task automatic test_around();
    for (int i = 0; i < 3; i++) begin
      send_sample(0, 0, 0);
      total++;
      if (state_out !== m_state) begin
        bad++;
        $display("FAIL around_confirm[%0d]: got st=%0d want %0d", i, state_out, m_state);
      end
    end
    if (state_out == 3'd4) run_turn(3'd4);
  endtask

  task automatic test_hyst();
    int rs[3] = '{2500, 1900, 1900};
    do_reset();
    start_run();
    for (int i = 0; i < 3; i++) begin
      send_sample(rs[i], 0, 0);
      total++;
      if (state_out !== m_state) begin
        bad++;
        $display("FAIL hyst_seq[%0d]: got st=%0d want %0d", i, state_out, m_state);
      end
    end
    total++;
`ifdef NAV_HYST_EN
    if (state_out !== 3'd3) begin
      bad++;
      $display("FAIL hyst_turn: got st=%0d want 3", state_out);
    end
`else
    if (state_out === 3'd3) begin
      bad++;
      $display("FAIL nohyst_turn: got st=%0d want not 3", state_out);
    end
`endif
    if (state_out == 3'd3) run_turn(3'd3);
  endtask

  task automatic test_midturn_reset();
    int n;
    do_reset();
    start_run();
    for (int i = 0; i < 3; i++) send_sample(0, 0, 2500);
    total++;
    if (state_out !== 3'd2 || rpm_left_setpoint !== RPM_W'(SLOW_R) ||
        rpm_right_setpoint !== RPM_W'(FAST_R)) begin
      bad++;
      $display("FAIL left_entry: got st=%0d L=%0d R=%0d want st=2 L=%0d R=%0d",
               state_out, rpm_left_setpoint, rpm_right_setpoint, SLOW_R, FAST_R);
    end
    repeat (TURN - 400 - 1) @(negedge clk_in);
    total++;
    if (state_out !== 3'd2) begin
      bad++;
      $display("FAIL left_at_400: got st=%0d want 2", state_out);
    end
    reset_in = 1'b1;
    @(negedge clk_in);
    total++;
    if (state_out !== 3'd0 || left_motor_en !== 1'b0 || right_motor_en !== 1'b0 ||
        rpm_left_setpoint !== '0 || rpm_right_setpoint !== '0 || turn_done !== 1'b0) begin
      bad++;
      $display("FAIL midturn_reset: got st=%0d en=%b%b L=%0d R=%0d done=%b want idle",
               state_out, left_motor_en, right_motor_en, rpm_left_setpoint,
               rpm_right_setpoint, turn_done);
    end
    reset_in = 1'b0;
    model_reset();
    @(negedge clk_in);
    m_state = 3'd1;
    total++;
    if (state_out !== 3'd1) begin
      bad++;
      $display("FAIL resume_forward: got st=%0d want 1", state_out);
    end
    for (int i = 0; i < 3; i++) send_sample(0, 0, 2500);
    n = 0;
    while (state_out != 3'd5 && n < TURN + 50) begin
      n++;
      @(negedge clk_in);
    end
    total++;
    if (state_out !== 3'd5) begin
      bad++;
      $display("FAIL reach_settle: got st=%0d want 5", state_out);
    end
    enable_switch = 1'b0;
    @(negedge clk_in);
    m_state = 3'd0;
    total++;
    if (state_out !== 3'd0 || left_motor_en !== 1'b0) begin
      bad++;
      $display("FAIL settle_disable: got st=%0d en=%b want st=0 en=0", state_out, left_motor_en);
    end
  endtask

  task automatic test_random();
    int vals[8] = '{0, 1799, 1800, 1801, 1999, 2000, 2001, 2500};
    int s[3];
    do_reset();
    start_run();
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 3; k++) begin
        s[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 65535))
                                           : vals[$urandom_range(0, 7)];
      end
      send_sample(s[0], s[1], s[2]);
      total++;
      if (state_out !== m_state) begin
        bad++;
        $display("FAIL rand[%0d] r=%0d f=%0d l=%0d: got st=%0d want %0d",
                 i, s[0], s[1], s[2], state_out, m_state);
      end
      if (m_state inside {3'd2, 3'd3, 3'd4} && state_out == m_state) run_turn(m_state);
      else if (state_out != m_state) begin
        do_reset();
        start_run();
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_right_turn();
    test_no_turn();
    test_around();
    test_hyst();
    test_midturn_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
